id_ex_stage: RTL

- ID/EX pipeline register that sits directly upstream of the ALU.
- Selects operands (rs1 or PC for src1; rs2 or immediate for src2) and resolves forwarding from MEM and WB.
- Stalls on load-use hazards and registers a one-hot ALU opcode plus both operands for the execute stage.
- Uses a valid/ready handshake on both sides, with a flush input for branch/trap redirect.

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select, MEM/WB forwarding, load-use stall, one-hot ALU op to EX.
// Latency: 1 cycle from ID capture to ALU inputs.
// Backpressure: holds all ex_* while ex_ready=0; id_ready drops on load-use hazard or full-and-stalled stage.
module id_ex_stage #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [ALU_OP_WIDTH-1:0] id_alu_opcode,
  input  logic [XLEN-1:0]         id_pc,
  input  logic [XLEN-1:0]         id_imm,
  input  logic [4:0]              id_rs1_addr,
  input  logic [4:0]              id_rs2_addr,
  input  logic [XLEN-1:0]         id_rs1_data,
  input  logic [XLEN-1:0]         id_rs2_data,
  input  logic                    id_src1_pc,
  input  logic                    id_src2_imm,
  input  logic [4:0]              id_rd_addr,
  input  logic                    id_rd_write,
  input  logic                    mem_rd_write,
  input  logic [4:0]              mem_rd_addr,
  input  logic [XLEN-1:0]         mem_rd_data,
  input  logic                    mem_data_ok,
  input  logic                    wb_rd_write,
  input  logic [4:0]              wb_rd_addr,
  input  logic [XLEN-1:0]         wb_rd_data,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [ALU_OP_WIDTH-1:0] ex_alu_opcode,
  output logic [XLEN-1:0]         ex_alu_src1,
  output logic [XLEN-1:0]         ex_alu_src2,
  output logic [XLEN-1:0]         ex_rs2_data,
  output logic [XLEN-1:0]         ex_pc,
  output logic [4:0]              ex_rd_addr,
  output logic                    ex_rd_write
);

  logic                    ex_valid_q, ex_valid_d;
  logic [ALU_OP_WIDTH-1:0] ex_alu_opcode_q, ex_alu_opcode_d;
  logic [XLEN-1:0]         ex_alu_src1_q, ex_alu_src1_d;
  logic [XLEN-1:0]         ex_alu_src2_q, ex_alu_src2_d;
  logic [XLEN-1:0]         ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]         ex_pc_q, ex_pc_d;
  logic [4:0]              ex_rd_addr_q, ex_rd_addr_d;
  logic                    ex_rd_write_q, ex_rd_write_d;

  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            rs1_nz, rs2_nz;
  logic            luh;
  logic            capture;

  // Forwarding muxes: x0 reads zero, MEM result wins over WB, otherwise regfile data.
  always_comb begin
    rs1_nz = (id_rs1_addr != 5'd0);
    rs2_nz = (id_rs2_addr != 5'd0);
    fwd_rs1 = id_rs1_data;
    fwd_rs2 = id_rs2_data;
    if (!rs1_nz)
      fwd_rs1 = '0;
    else if (mem_rd_write && (mem_rd_addr == id_rs1_addr))
      fwd_rs1 = mem_rd_data;
    else if (wb_rd_write && (wb_rd_addr == id_rs1_addr))
      fwd_rs1 = wb_rd_data;
    if (!rs2_nz)
      fwd_rs2 = '0;
    else if (mem_rd_write && (mem_rd_addr == id_rs2_addr))
      fwd_rs2 = mem_rd_data;
    else if (wb_rd_write && (wb_rd_addr == id_rs2_addr))
      fwd_rs2 = wb_rd_data;
  end

  // Load-use hazard and handshake; rs2 always counts as used because stores need it as data.
  always_comb begin
    luh = id_valid && mem_rd_write && !mem_data_ok &&
          ((!id_src1_pc && rs1_nz && (mem_rd_addr == id_rs1_addr)) ||
           (rs2_nz && (mem_rd_addr == id_rs2_addr)));
    id_ready = (!ex_valid_q || ex_ready) && !luh && !rst;
    capture  = id_valid && id_ready && !flush;
  end

  // Next-state for the EX register: flush > capture > hold > drain.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_alu_opcode_d = ex_alu_opcode_q;
    ex_alu_src1_d   = ex_alu_src1_q;
    ex_alu_src2_d   = ex_alu_src2_q;
    ex_rs2_data_d   = ex_rs2_data_q;
    ex_pc_d         = ex_pc_q;
    ex_rd_addr_d    = ex_rd_addr_q;
    ex_rd_write_d   = ex_rd_write_q;
    if (flush) begin
      ex_valid_d      = 1'b0;
      ex_alu_opcode_d = '0;
      ex_rd_write_d   = 1'b0;
    end else if (capture) begin
      ex_valid_d      = 1'b1;
      ex_alu_opcode_d = id_alu_opcode;
      ex_alu_src1_d   = id_src1_pc  ? id_pc  : fwd_rs1;
      ex_alu_src2_d   = id_src2_imm ? id_imm : fwd_rs2;
      ex_rs2_data_d   = fwd_rs2;
      ex_pc_d         = id_pc;
      ex_rd_addr_d    = id_rd_addr;
      ex_rd_write_d   = id_rd_write;
    end else if (ex_valid_q && !ex_ready) begin
      // downstream stalled: keep everything as-is, MEM/WB are frozen alongside
    end else begin
      // consumed (or already empty) with nothing new: bubble, data fields left stale
      ex_valid_d      = 1'b0;
      ex_alu_opcode_d = '0;
      ex_rd_write_d   = 1'b0;
    end
  end

  // EX register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_alu_opcode_q <= '0;
      ex_alu_src1_q   <= '0;
      ex_alu_src2_q   <= '0;
      ex_rs2_data_q   <= '0;
      ex_pc_q         <= '0;
      ex_rd_addr_q    <= '0;
      ex_rd_write_q   <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_alu_opcode_q <= ex_alu_opcode_d;
      ex_alu_src1_q   <= ex_alu_src1_d;
      ex_alu_src2_q   <= ex_alu_src2_d;
      ex_rs2_data_q   <= ex_rs2_data_d;
      ex_pc_q         <= ex_pc_d;
      ex_rd_addr_q    <= ex_rd_addr_d;
      ex_rd_write_q   <= ex_rd_write_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_opcode = ex_alu_opcode_q;
  assign ex_alu_src1   = ex_alu_src1_q;
  assign ex_alu_src2   = ex_alu_src2_q;
  assign ex_rs2_data   = ex_rs2_data_q;
  assign ex_pc         = ex_pc_q;
  assign ex_rd_addr    = ex_rd_addr_q;
  assign ex_rd_write   = ex_rd_write_q;

endmodule
